// File: rtl/riscv_lsu.sv
// riscv_lsu: core data port to byte-enabled word bus, with timeout abort.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module riscv_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        err_o,
  output logic        misalign_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic        latch;
  logic        cap;
  logic        tmo;
  logic        acc;
  logic        done;

  logic [1:0]  off_in;
  logic [3:0]  be_in;
  logic [31:0] wd_in;
  logic        mis_in;

  logic        we_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic [31:0] rd_q;
  logic        err_q;
  logic        mis_q;
  logic [CW-1:0] cnt_q;

  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] ext;

  assign off_in = core_addr_i[1:0];
  assign acc    = (state_q == ACCESS);
  assign done   = (state_q == DONE);

  // Lane placement of the incoming request
  always_comb begin
    be_in = 4'b1111;
    wd_in = core_wd_i;
    unique case (core_size_i[1:0])
      2'b00: begin
        be_in = 4'b0001 << off_in;
        wd_in = {4{core_wd_i[7:0]}};
      end
      2'b01: begin
        be_in = 4'b0011 << {off_in[1], 1'b0};
        wd_in = {2{core_wd_i[15:0]}};
      end
      default: begin
        be_in = 4'b1111;
        wd_in = core_wd_i;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_in = ((core_size_i[1:0] == 2'b01) & off_in[0])
                | (core_size_i[1] & (off_in != 2'b00));
  assign misalign_o = done & mis_q;
`else
  assign mis_in = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    cap     = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (core_req_i) begin
          latch   = 1'b1;
          state_d = mis_in ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        // ready on the last allowed cycle still completes cleanly
        if (mem_ready_i) begin
          cap     = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_MAX) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      size_q <= 3'd0;
      off_q  <= 2'd0;
      addr_q <= '0;
      be_q   <= 4'd0;
      wd_q   <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
      mis_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (latch) begin
        we_q   <= core_we_i;
        size_q <= core_size_i;
        off_q  <= off_in;
        addr_q <= core_addr_i[31:2];
        be_q   <= be_in;
        wd_q   <= wd_in;
        err_q  <= 1'b0;
        mis_q  <= mis_in;
        cnt_q  <= '0;
      end else if (acc) begin
        cnt_q  <= cnt_q + CW'(1);
      end
      if (cap) begin
        rd_q <= mem_rd_i;
      end
      if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    sel_b = rd_q[7:0];
    unique case (off_q)
      2'd0: sel_b = rd_q[7:0];
      2'd1: sel_b = rd_q[15:8];
      2'd2: sel_b = rd_q[23:16];
      2'd3: sel_b = rd_q[31:24];
      default: sel_b = rd_q[7:0];
    endcase
  end

  assign sel_h = off_q[1] ? rd_q[31:16] : rd_q[15:0];

  always_comb begin
    ext = rd_q;
    unique case (size_q)
      3'd0: ext = {{24{sel_b[7]}}, sel_b};
      3'd1: ext = {{16{sel_h[15]}}, sel_h};
      3'd4: ext = {24'd0, sel_b};
      3'd5: ext = {16'd0, sel_h};
      default: ext = rd_q;
    endcase
  end

  assign core_rd_o = (done & ~(err_q | mis_q | we_q)) ? ext : 32'd0;
  assign core_stall_o = core_req_i & ~done;

  assign mem_req_o  = acc;
  assign mem_we_o   = acc & we_q;
  assign mem_be_o   = acc ? be_q : 4'd0;
  assign mem_addr_o = acc ? {addr_q, 2'b00} : 32'd0;
  assign mem_wd_o   = acc ? wd_q : 32'd0;

  assign err_o = done & err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: scoreboard bench for riscv_lsu with TIMEOUT = 4.
// Misalign expectations follow LSU_MISALIGN_TRAP_EN.
module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;
  logic        err_o;
  logic        misalign_o;

  riscv_lsu #(.TIMEOUT(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i),
    .err_o        (err_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        mis;
    int          stall;
    int          acc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  int cfg_wait = 0;
  logic [31:0] cfg_rdata = 32'd0;
  int stall_n = 0;
  int acc_n = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction

  function automatic exp_t mk(logic [31:0] rd, logic err, logic mis,
                              int stall, int acc, logic [31:0] addr,
                              logic [3:0] be, logic we, logic [31:0] wd);
    exp_t e;
    e.rd = rd; e.err = err; e.mis = mis;
    e.stall = stall; e.acc = acc;
    e.addr = addr; e.be = be; e.we = we; e.wd = wd;
    return e;
  endfunction

  // Memory model: ready after cfg_wait stalled cycles; junk when idle
  initial begin
    int rc;
    rc = 0;
    mem_ready_i = 1'b0;
    mem_rd_i = 32'hDEAD_0000;
    forever begin
      @(negedge clk_i);
      if (mem_req_o) begin
        mem_ready_i = (rc == cfg_wait);
        mem_rd_i = (rc == cfg_wait) ? cfg_rdata : 32'hDEAD_0001;
        rc++;
      end else begin
        rc = 0;
        mem_ready_i = 1'b1;
        mem_rd_i = 32'hDEAD_0002;
      end
    end
  end

  // Monitor: bus fields every ACCESS cycle, result on completion
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        if (mem_req_o) begin
          acc_n++;
          if (q.size() == 0) begin
            chk("bus_unexpected", 32'd1, 32'd0);
          end else begin
            e = q[0];
            chk("bus_addr", mem_addr_o, e.addr);
            chk("bus_be", {28'd0, mem_be_o}, {28'd0, e.be});
            chk("bus_we", {31'd0, mem_we_o}, {31'd0, e.we});
            chk("bus_wd", mem_wd_o, e.wd);
          end
        end
        if (core_req_i && core_stall_o) stall_n++;
        if (core_req_i && !core_stall_o) begin
          if (q.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("rd", core_rd_o, e.rd);
            chk("err", {31'd0, err_o}, {31'd0, e.err});
            chk("misalign", {31'd0, misalign_o}, {31'd0, e.mis});
            chk("stall_cycles", stall_n, e.stall);
            chk("access_cycles", acc_n, e.acc);
          end
          stall_n = 0;
          acc_n = 0;
        end else if (err_o || misalign_o) begin
          chk("stray_pulse", {30'd0, err_o, misalign_o}, 32'd0);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdata, input int wt,
                       input exp_t e);
    int n;
    q.push_back(e);
    cfg_wait = wt;
    cfg_rdata = rdata;
    core_req_i = 1'b1;
    core_we_i = we;
    core_size_i = sz;
    core_addr_i = a;
    core_wd_i = wd;
    n = 0;
    @(negedge clk_i);
    while (core_stall_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    if (core_stall_o) begin
      chk("done_timeout", 32'd1, 32'd0);
      q.delete();
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_req();
    core_req_i = 1'b0;
    core_we_i = 1'b0;
    core_size_i = 3'd0;
    core_addr_i = 32'd0;
    core_wd_i = 32'd0;
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i = 1'b1;
    idle_req();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_rd", core_rd_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_stall0", {31'd0, core_stall_o}, 32'd0);
    core_req_i = 1'b1;
    #1;
    chk("rst_stall1", {31'd0, core_stall_o}, 32'd1);
    core_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    mon_en = 1'b1;
    @(posedge clk_i);
    #1;

    issue(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0,
          mk(32'hFFFF_FF80, 0, 0, 2, 1, 32'h100, 4'b1000, 0, 32'h0));
    issue(1'b1, 3'd1, 32'h202, 32'hDEAD_BEEF, 32'h0, 3,
          mk(32'h0, 0, 0, 5, 4, 32'h200, 4'b1100, 1, 32'hBEEF_BEEF));
    issue(1'b0, 3'd5, 32'h002, 32'h0, 32'h8001_0000, 0,
          mk(32'h0000_8001, 0, 0, 2, 1, 32'h0, 4'b1100, 0, 32'h0));
    issue(1'b0, 3'd2, 32'h004, 32'h0, 32'h5555_5555, -1,
          mk(32'h0, 1, 0, 5, 4, 32'h4, 4'b1111, 0, 32'h0));
    issue(1'b0, 3'd2, 32'h008, 32'h0, 32'h1234_5678, 3,
          mk(32'h1234_5678, 0, 0, 5, 4, 32'h8, 4'b1111, 0, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 3'd2, 32'h001, 32'h0, 32'hCAFE_F00D, 0,
          mk(32'h0, 0, 1, 1, 0, 32'h0, 4'b1111, 0, 32'h0));
`else
    issue(1'b0, 3'd2, 32'h001, 32'h0, 32'hCAFE_F00D, 0,
          mk(32'hCAFE_F00D, 0, 0, 2, 1, 32'h0, 4'b1111, 0, 32'h0));
`endif
    issue(1'b1, 3'd0, 32'h301, 32'h1234_56A5, 32'h0, 0,
          mk(32'h0, 0, 0, 2, 1, 32'h300, 4'b0010, 1, 32'hA5A5_A5A5));
    issue(1'b0, 3'd1, 32'h006, 32'h0, 32'h9ABC_0000, 0,
          mk(32'hFFFF_9ABC, 0, 0, 2, 1, 32'h4, 4'b1100, 0, 32'h0));
    issue(1'b0, 3'd4, 32'h00A, 32'h0, 32'h00C3_0000, 0,
          mk(32'h0000_00C3, 0, 0, 2, 1, 32'h8, 4'b0100, 0, 32'h0));
    issue(1'b1, 3'd2, 32'h010, 32'h1122_3344, 32'h0, 1,
          mk(32'h0, 0, 0, 3, 2, 32'h10, 4'b1111, 1, 32'h1122_3344));
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 3'd1, 32'h003, 32'h0, 32'h7FFF_1111, 0,
          mk(32'h0, 0, 1, 1, 0, 32'h0, 4'b1100, 0, 32'h0));
`else
    issue(1'b0, 3'd1, 32'h003, 32'h0, 32'h7FFF_1111, 0,
          mk(32'h0000_7FFF, 0, 0, 2, 1, 32'h0, 4'b1100, 0, 32'h0));
`endif
    issue(1'b0, 3'd0, 32'h000, 32'hFFFF_FFFF, 32'h0000_007F, 0,
          mk(32'h0000_007F, 0, 0, 2, 1, 32'h0, 4'b0001, 0, 32'hFFFF_FFFF));
    issue(1'b0, 3'd3, 32'h00C, 32'hAABB_CCDD, 32'h8765_4321, 0,
          mk(32'h8765_4321, 0, 0, 2, 1, 32'hC, 4'b1111, 0, 32'hAABB_CCDD));
    idle_req();
    repeat (3) @(posedge clk_i);
    #1;
    chk("queue_drained", q.size(), 32'd0);

    // Reset in the middle of an access
    mon_en = 1'b0;
    cfg_wait = -1;
    core_req_i = 1'b1;
    core_size_i = 3'd2;
    core_addr_i = 32'h20;
    n = 0;
    @(negedge clk_i);
    while (!mem_req_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    chk("rst_test_req_seen", {31'd0, mem_req_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_async_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_async_stall", {31'd0, core_stall_o}, 32'd1);
    idle_req();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("rst_no_err", {31'd0, err_o}, 32'd0);
      chk("rst_no_req", {31'd0, mem_req_o}, 32'd0);
    end
    @(posedge clk_i);
    #1;
    stall_n = 0;
    acc_n = 0;
    mon_en = 1'b1;
    issue(1'b0, 3'd2, 32'h024, 32'h0, 32'h0BAD_F00D, 2,
          mk(32'h0BAD_F00D, 0, 0, 4, 3, 32'h24, 4'b1111, 0, 32'h0));
    idle_req();
    repeat (2) @(posedge clk_i);
    #1;
    chk("queue_final", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
